// File: rtl/apb_master_slave_if.sv
// System request/response and exported APB bus signals for apb_master_slave.
// master: the design's view (drives bus and status); slave: the requester/observer view.
interface apb_master_slave_if;
   logic [7:0]  addr;
   logic [31:0] data;
   logic        data_valid;
   logic        data_dir;
   logic [31:0] wait_cycle;
   logic [31:0] read_out_data;
   logic        transaction_done;
   logic        transaction_error;
   logic        apb_selx;
   logic        apb_en;
   logic        apb_write;
   logic [7:0]  apb_addr;
   logic [31:0] apb_wdata;
   logic [31:0] apb_rdata;
   logic        apb_ready;
   logic        apb_slverr;

   modport master (
      input  addr, data, data_valid, data_dir, wait_cycle,
      output read_out_data, transaction_done, transaction_error,
      output apb_selx, apb_en, apb_write, apb_addr, apb_wdata,
      output apb_rdata, apb_ready, apb_slverr
   );

   modport slave (
      output addr, data, data_valid, data_dir, wait_cycle,
      input  read_out_data, transaction_done, transaction_error,
      input  apb_selx, apb_en, apb_write, apb_addr, apb_wdata,
      input  apb_rdata, apb_ready, apb_slverr
   );
endinterface

// File: rtl/apb_master_slave.sv
// APB master FSM plus register-file slave; done pulses the cycle after ACCESS sees ready or times out
// (min 3 cycles from acceptance). Requests arriving outside IDLE are dropped, not queued.
module apb_master_slave #(
   parameter int MEM_DEPTH      = 64,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                apb_clk,
   input  logic                apb_reset,
   apb_master_slave_if.master  bus
);
   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] acc_cnt;
   logic          done_nxt, err_nxt;
   logic [31:0]   slv_cnt;
   logic [31:0]   mem [MEM_DEPTH];
   logic [AW-1:0] mem_idx;
   logic          addr_ok, xfer_ok;

   assign bus.apb_selx   = (state != IDLE);
   assign bus.apb_en     = (state == ACCESS);
   assign bus.apb_ready  = bus.apb_selx & bus.apb_en & (slv_cnt >= bus.wait_cycle);
   assign addr_ok        = ({24'd0, bus.apb_addr} < 32'(MEM_DEPTH));
   assign bus.apb_slverr = bus.apb_ready & ~addr_ok;
   assign xfer_ok        = bus.apb_ready & addr_ok;
   assign mem_idx        = bus.apb_addr[AW-1:0];
   assign bus.apb_rdata  = (xfer_ok & ~bus.apb_write) ? mem[mem_idx] : '0;

   always_ff @(posedge apb_clk) begin
      if (apb_reset) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE:   if (bus.data_valid) state_nxt = SETUP;
         SETUP:  state_nxt = ACCESS;
         ACCESS: begin
            // ready takes priority over timeout when both land on the same cycle
            if (bus.apb_ready) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               err_nxt   = bus.apb_slverr;
            end else if (acc_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               err_nxt   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge apb_clk) begin
      if (apb_reset) begin
         acc_cnt               <= '0;
         bus.apb_write         <= 1'b0;
         bus.apb_addr          <= '0;
         bus.apb_wdata         <= '0;
         bus.read_out_data     <= '0;
         bus.transaction_done  <= 1'b0;
         bus.transaction_error <= 1'b0;
      end else begin
         bus.transaction_done  <= done_nxt;
         bus.transaction_error <= err_nxt;
         if (state == IDLE && bus.data_valid) begin
            bus.apb_addr  <= bus.addr;
            bus.apb_wdata <= bus.data;
            bus.apb_write <= bus.data_dir;
         end
         if (state == ACCESS && state_nxt == ACCESS) acc_cnt <= acc_cnt + 1'b1;
         else                                         acc_cnt <= '0;
         if (xfer_ok && !bus.apb_write) bus.read_out_data <= bus.apb_rdata;
      end
   end

   always_ff @(posedge apb_clk) begin
      if (apb_reset) begin
         slv_cnt <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else begin
         slv_cnt <= (bus.apb_selx & bus.apb_en) ? slv_cnt + 32'd1 : '0;
         if (xfer_ok && bus.apb_write) mem[mem_idx] <= bus.apb_wdata;
      end
   end
endmodule

// File: tb/tb_apb_master_slave.sv
// Randomised bench for apb_master_slave: stimulus pushes expected completions, a negedge monitor
// checks bus phases and pops the scoreboard on every done pulse.
module tb_apb_master_slave;
   localparam int T     = 16;
   localparam int DEPTH = 64;

   typedef struct {
      bit          err;
      logic [31:0] rd;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   in_reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   int          phase = 0;
   int          acc_k = 0;
   int          ready_k = -1;
   logic [7:0]  cur_addr = '0;
   logic        cur_dir = 1'b0;
   logic [31:0] exp_rdata = '0;
   logic [31:0] mem_m [DEPTH];
   logic [31:0] rd_m = '0;
   exp_t        q[$];
   exp_t        me;

   apb_master_slave_if bus ();

   apb_master_slave #(.MEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(T)) dut (
      .apb_clk   (clk),
      .apb_reset (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      rd_m = '0;
   endtask

   task automatic do_req(input bit dir, input logic [7:0] a, input logic [31:0] d,
                         input int w, input int gap, input bit post_rst);
      exp_t e;
      int   n;
      bit   tmo, err;
      repeat (gap) begin
         @(negedge clk);
         bus.data_valid = 1'b0;
      end
      @(negedge clk);
      if (post_rst) begin
         chk32("rst_read_out", bus.read_out_data, 32'd0);
         chk1("rst_done", bus.transaction_done, 1'b0);
         chk1("rst_error", bus.transaction_error, 1'b0);
         chk1("rst_selx", bus.apb_selx, 1'b0);
         chk1("rst_en", bus.apb_en, 1'b0);
         chk1("rst_write", bus.apb_write, 1'b0);
         chk32("rst_addr", {24'd0, bus.apb_addr}, 32'd0);
         chk32("rst_wdata", bus.apb_wdata, 32'd0);
         rst = 1'b0;
         in_reset = 1'b0;
      end
      bus.data_valid = 1'b1;
      bus.addr       = a;
      bus.data       = d;
      bus.data_dir   = dir;
      bus.wait_cycle = w;
      tmo = (w >= T);
      n   = tmo ? T : w + 1;
      err = tmo || (a >= DEPTH);
      exp_rdata = '0;
      if (!err) begin
         if (dir) mem_m[a[5:0]] = d;
         else begin
            rd_m      = mem_m[a[5:0]];
            exp_rdata = rd_m;
         end
      end
      cur_addr = a;
      cur_dir  = dir;
      ready_k  = tmo ? -1 : w;
      e.err = err;
      e.rd  = rd_m;
      e.cyc = cyc + 2 + n;
      q.push_back(e);
      @(posedge clk);
      phase = 1;
      acc_k = 0;
      for (int k = 0; k <= n; k++) begin
         @(negedge clk);
         bus.data_valid = 1'($urandom_range(0, 1));
         bus.addr       = 8'($urandom);
         bus.data       = $urandom;
         bus.data_dir   = 1'($urandom_range(0, 1));
         @(posedge clk);
         if (k == 0)      phase = 2;
         else if (k == n) phase = 0;
         else             acc_k++;
      end
   endtask

   task automatic abort_req(input logic [7:0] a, input logic [31:0] d, input int w);
      @(negedge clk);
      bus.data_valid = 1'b1;
      bus.addr       = a;
      bus.data       = d;
      bus.data_dir   = 1'b1;
      bus.wait_cycle = w;
      cur_addr = a;
      cur_dir  = 1'b1;
      ready_k  = -1;
      @(posedge clk);
      phase = 1;
      acc_k = 0;
      @(negedge clk);
      bus.data_valid = 1'b0;
      @(posedge clk);
      phase = 2;
      repeat (2) begin
         @(negedge clk);
         @(posedge clk);
         acc_k++;
      end
      @(negedge clk);
      rst = 1'b1;
      in_reset = 1'b1;
      @(posedge clk);
      phase = 0;
      clear_model();
   endtask

   always @(negedge clk) begin
      if (!in_reset) begin
         chk1("selx", bus.apb_selx, phase != 0);
         chk1("en", bus.apb_en, phase == 2);
         chk1("ready", bus.apb_ready, (phase == 2) && (acc_k == ready_k));
         if (bus.apb_ready) begin
            chk1("slverr", bus.apb_slverr, cur_addr >= DEPTH);
            if (!cur_dir) chk32("rdata", bus.apb_rdata, exp_rdata);
         end
         if (bus.transaction_done) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done at cycle %0d: got done=1 expected no completion", cyc);
            end else begin
               me = q.pop_front();
               chk32("done_cycle", cyc, me.cyc);
               chk1("done_error", bus.transaction_error, me.err);
               chk32("read_out_data", bus.read_out_data, me.rd);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit          dir;
      logic [7:0]  a;
      int          w;
      bus.data_valid = 1'b0;
      bus.addr       = '0;
      bus.data       = '0;
      bus.data_dir   = 1'b0;
      bus.wait_cycle = '0;
      clear_model();
      repeat (3) @(posedge clk);

      do_req(1'b1, 8'd4,   32'd10, 0, 0, 1'b1);
      do_req(1'b1, 8'd5,   32'd12, 0, 0, 1'b0);
      do_req(1'b0, 8'd4,   32'd0,  0, 1, 1'b0);
      do_req(1'b0, 8'd5,   32'd0,  0, 0, 1'b0);
      do_req(1'b1, 8'd100, 32'd12, 0, 0, 1'b0);
      do_req(1'b0, 8'd100, 32'd0,  0, 0, 1'b0);
      do_req(1'b1, 8'd63,  32'hdead_beef, 0, 0, 1'b0);
      do_req(1'b1, 8'd64,  32'h1234_5678, 0, 2, 1'b0);
      do_req(1'b0, 8'd63,  32'd0,  0, 0, 1'b0);
      do_req(1'b1, 8'd1,   32'd7,  3, 0, 1'b0);
      do_req(1'b1, 8'd1,   32'd9,  T + 4, 0, 1'b0);
      do_req(1'b0, 8'd1,   32'd0,  T - 1, 0, 1'b0);
      do_req(1'b0, 8'd5,   32'd0,  T, 0, 1'b0);

      abort_req(8'd2, 32'd5, 10);
      do_req(1'b0, 8'd2, 32'd0, 0, 0, 1'b1);
      do_req(1'b0, 8'd4, 32'd0, 0, 0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         dir = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
         w   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(T - 2, T + 3)) : int'($urandom_range(0, 4));
         do_req(dir, a, $urandom, w, int'($urandom_range(0, 2)), 1'b0);
      end

      @(negedge clk);
      bus.data_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk32("queue_drained", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/apb_master_slave.md
APB_MASTER_SLAVE -- requirements
Module: apb_master_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64, number of 32-bit slave registers (valid addresses 0..MEM_DEPTH-1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles the master waits for apb_ready.
REQ-003 SHALL have a single clock and a synchronous, active-high reset.
REQ-004 apb_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 apb_reset  in  1  synchronous, active-high reset.
REQ-006 addr  in  8  system request address.
REQ-007 data  in  32  system write data.
REQ-008 data_valid  in  1  request strobe, sampled only in IDLE.
REQ-009 data_dir  in  1  1 = write, 0 = read.
REQ-010 wait_cycle  in  32  number of wait states the slave inserts per transfer.
REQ-011 read_out_data  out  32  last successful read data.
REQ-012 transaction_done  out  1  one-cycle completion pulse.
REQ-013 transaction_error  out  1  qualifies transaction_done; 1 = slave error or timeout.
REQ-014 apb_selx, apb_en, apb_write  out  1 each  APB bus controls (master-driven, exported).
REQ-015 apb_addr  out  8; apb_wdata, apb_rdata  out  32; apb_ready, apb_slverr  out  1: exported APB bus.

Function
REQ-016 Master FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-017 IDLE: data_valid=1 at an edge -> latch addr, data, data_dir into apb_addr/apb_wdata/apb_write; go to SETUP.
REQ-018 SETUP: apb_selx=1, apb_en=0; unconditionally go to ACCESS next edge.
REQ-019 ACCESS: apb_selx=1, apb_en=1; address, write data and direction held stable until exit.
REQ-020 ACCESS with apb_ready=1 at an edge: return to IDLE, drop selx/en, pulse transaction_done for exactly the next cycle with transaction_error=apb_slverr.
REQ-021 Read completing without error SHALL load read_out_data from apb_rdata at that edge; otherwise read_out_data unchanged.
REQ-022 Master SHALL count ACCESS cycles; when TIMEOUT_CYCLES elapse without apb_ready: go to IDLE, done=1 and error=1 for one cycle, no slave side effect.
REQ-023 data_valid outside IDLE SHALL be ignored; a new request SHALL be accepted the first IDLE edge after done (back-to-back allowed).
REQ-024 Slave SHALL count cycles with selx&en; apb_ready = selx & en & (count >= wait_cycle), combinational; count clears when en=0.
REQ-025 wait_cycle=0 -> ready in first ACCESS cycle; minimum transfer = 2 cycles (SETUP+ACCESS), done in 3rd.
REQ-026 apb_slverr = apb_ready & (apb_addr >= MEM_DEPTH).
REQ-027 Write commit: at the edge with selx&en&ready&write&!slverr, mem[apb_addr] <= apb_wdata.
REQ-028 apb_rdata = mem[apb_addr] when selx&en&ready&!write&!slverr, else 0.
REQ-029 Error writes SHALL not modify memory; error reads SHALL return 0 on apb_rdata.
REQ-030 apb_selx, apb_en, apb_ready SHALL never be 1 outside a transfer.

Reset
REQ-031 apb_reset=1 at an edge: FSM->IDLE, counters 0, all master outputs (selx, en, write, addr, wdata, read_out_data, done, error) 0.
REQ-032 Reset SHALL clear all MEM_DEPTH slave registers to 0.
REQ-033 Reset mid-transfer SHALL abort silently: no done pulse, no memory write.
REQ-034 First request SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-035 wait_cycle=0; write 10@4, write 12@5 -> each done pulse with error=0, 3 cycles from acceptance; mem[4]=10, mem[5]=12.
REQ-036 Then read @4, read @5 -> read_out_data 10 then 12, error=0.
REQ-037 Write 12@100 -> done with error=1, apb_slverr seen in ACCESS, no memory change.
REQ-038 Read @100 -> done with error=1, read_out_data unchanged.
REQ-039 wait_cycle=3; write 7@1 -> ACCESS lasts 4 cycles, error=0; wait_cycle=TIMEOUT_CYCLES+4 -> done with error=1 after TIMEOUT_CYCLES ACCESS cycles, mem[1] unchanged.
REQ-040 Assert reset during ACCESS of write 5@2 -> no done pulse, outputs 0 next cycle, mem[2]=0.
